// File: rtl/fifo_stream_reader.sv
// Pops words from a show-ahead FIFO and presents them as a valid/ready stream framed into FRAME_LEN beats.
// Optional feature: define FIFO_STREAM_READER_PARITY_EN to add the m_parity output.
module fifo_stream_reader #(
  parameter int DBIT      = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd_en,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DBIT-1:0] m_data,
  output logic            m_last,
`ifdef FIFO_STREAM_READER_PARITY_EN
  output logic            m_parity,
`endif
  output logic [15:0]     frame_count
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] beat_idx;
  logic             pop;
  logic             accept;

  // NOTE: pop is pure combinational logic with no feedback, so a continuous
  // assign cannot infer a latch; gating with rst keeps the FIFO untouched in reset.
  assign pop        = !rst && enable && !flush && !fifo_empty && (!m_valid || m_ready);
  assign accept     = m_valid && m_ready;
  assign fifo_rd_en = pop;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      beat_idx    <= '0;
      frame_count <= '0;
`ifdef FIFO_STREAM_READER_PARITY_EN
      m_parity    <= 1'b0;
`endif
    end else if (flush) begin
      // Flush wins over any handshake in the same cycle; the dropped beat is never counted.
      state    <= EMPTY;
      m_valid  <= 1'b0;
      beat_idx <= '0;
    end else begin
      if (accept && m_last) begin
        frame_count <= frame_count + 16'd1;
      end

      if (pop) begin
        state    <= HOLD;
        m_valid  <= 1'b1;
        m_data   <= fifo_rd_data;
        m_last   <= (beat_idx == LAST_IDX);
        beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);
`ifdef FIFO_STREAM_READER_PARITY_EN
        m_parity <= ^fifo_rd_data;
`endif
      end else begin
        case (state)
          EMPTY: state <= EMPTY;
          HOLD: begin
            if (m_ready) begin
              state   <= EMPTY;
              m_valid <= 1'b0;
            end
          end
          default: begin
            state   <= EMPTY;
            m_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DBIT, default 8, width of data words.
REQ-002 Parameter FRAME_LEN, default 4, beats per frame; legal range 1..256.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  permits new FIFO pops when high.
REQ-007 flush  input  1  discards the held beat and restarts frame alignment.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_rd_data  input  DBIT  FIFO head word, show-ahead, valid whenever fifo_empty=0.
REQ-010 fifo_rd_en  output  1  pop strobe to the FIFO; combinational.
REQ-011 m_valid  output  1  output beat valid.
REQ-012 m_ready  input  1  downstream accepts beat.
REQ-013 m_data  output  DBIT  output beat data.
REQ-014 m_last  output  1  final beat of the current frame.
REQ-015 frame_count  output  16  number of completed frames, modulo 2^16.

Function
REQ-016 The block SHALL implement FSM states EMPTY (m_valid=0) and HOLD (m_valid=1); m_valid is a registered output.
REQ-017 The block SHALL compute pop = enable && !flush && !fifo_empty && (!m_valid || m_ready), and drive fifo_rd_en = pop.
REQ-018 On pop, the block SHALL register m_data <= fifo_rd_data and m_last <= (beat_idx == FRAME_LEN-1), and SHALL enter or stay in HOLD; latency is fifo_rd_en high to m_valid high in 1 cycle.
REQ-019 In HOLD with m_ready=1 and no pop, the block SHALL go to EMPTY; back-to-back pop and accept SHALL sustain 1 beat per cycle.
REQ-020 In HOLD with m_ready=0, m_data, m_last and m_valid SHALL stay stable, and fifo_rd_en SHALL be 0.
REQ-021 beat_idx (internal, ceil(log2(FRAME_LEN)) bits, minimum 1) SHALL increment on each pop and wrap from FRAME_LEN-1 to 0.
REQ-022 When FRAME_LEN=1, every beat SHALL have m_last=1.
REQ-023 frame_count SHALL increment on the cycle m_valid && m_ready && m_last, and SHALL wrap from 16'hFFFF to 0.
REQ-024 While enable=0, the block SHALL pop nothing; a held beat still drains on m_ready, and beat_idx is preserved.
REQ-025 While flush=1, the block SHALL force m_valid<=0, beat_idx<=0 and fifo_rd_en=0; flush beats a simultaneous handshake, which SHALL NOT count toward frame_count.
REQ-026 fifo_empty=1 while in EMPTY SHALL cause no pop and no state change.

Reset
REQ-027 On rst=1 at posedge, the block SHALL set: state EMPTY, m_valid=0, m_data=0, m_last=0, beat_idx=0, frame_count=0.
REQ-028 fifo_rd_en SHALL be 0 during any cycle in which rst=1.
REQ-029 Reset mid-frame SHALL discard any held beat with no further handshake; the first pop after reset SHALL start a new frame at beat_idx 0.

Configuration
REQ-030 With macro FIFO_STREAM_READER_PARITY_EN defined, the block SHALL add output m_parity (1 bit), registered with m_data, equal to the even parity (XOR reduce) of the popped word, and reset to 0.
REQ-031 Without FIFO_STREAM_READER_PARITY_EN, the m_parity port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Streaming: FIFO holds 0x11,0x22,0x33,0x44,0x55; enable=1; m_ready=1 -> five beats on consecutive cycles, m_last=1 on 0x44 only, frame_count=1.
REQ-033 Backpressure: beat 0xA5 held with m_ready=0 for 3 cycles -> m_data=0xA5 stable, fifo_rd_en=0 throughout, beat accepted on the cycle m_ready=1.
REQ-034 Flush: after 2 beats of a frame, pulse flush with m_valid=1 -> m_valid=0 next cycle; the next pop has beat_idx 0, so m_last falls on the 4th subsequent beat.
REQ-035 Wrap: preload frame_count to 0xFFFF by completing 65535 frames, then complete one more frame -> frame_count=0x0000.
REQ-036 Reset mid-frame: rst for 1 cycle while in HOLD -> m_valid=0, frame_count=0, fifo_rd_en=0 in that cycle.
REQ-037 Parity (macro defined): pop 0x07 -> m_parity=1; pop 0x03 -> m_parity=0.
